cic_interpolator: RTL and testbench

- Transmit-path CIC interpolating filter. It is the counterpart to the receive-side CIC decimator.
- It accepts low-rate baseband samples through a valid/ready handshake and upsamples them by RATE using STAGES comb stages, zero-stuffing and STAGES integrators.
- It emits one high-rate sample per clock-enable tick toward the DAC/upconverter path.
- One instance is used per I/Q rail.

---
 rtl/cic_interpolator.sv | 130 +++++++++++++
 tb/tb_cic_interpolator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interpolator.sv
// CIC interpolating filter: comb chain at the input rate, zero-stuff, integrator chain per ce tick.
// Latency: a sample consumed on ce tick t first reaches out_data on the strobe of ce tick t+STAGES.
// Backpressure: one-entry holding register, in_ready = !full; an empty register on a phase-0 tick inserts zero and sets underflow.
module cic_interpolator #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int RATE      = 4,
  parameter int STAGES    = 3,
  parameter int ACC_WIDTH = IN_WIDTH + STAGES * $clog2(RATE)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        ce,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_strobe,
  output logic                        underflow,
  input  logic                        clr_underflow
);

  localparam int PW = $clog2(RATE);
  localparam logic [PW-1:0] LAST_PHASE = PW'(RATE - 1);

  // Holding register and phase state.
  logic signed [IN_WIDTH-1:0]  hold_q;
  logic                        full_q;
  logic [PW-1:0]               phase_q;

  logic                        consume;
  logic                        load;
  logic signed [ACC_WIDTH-1:0] x_acc;

  // A phase-0 tick is the only point where a low-rate sample enters the filter.
  assign consume  = ce && (phase_q == '0);
  // Ready is derived from the registered full flag only, so a same-cycle
  // consume never opens the register for a load in that cycle.
  assign in_ready = !full_q;
  assign load     = in_valid && in_ready;
  // Missing data feeds a zero into the comb chain rather than stalling.
  assign x_acc    = full_q ? ACC_WIDTH'(hold_q) : '0;

  // Holding register: a load takes priority over the consume that empties it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else if (load) begin
      hold_q <= in_data;
      full_q <= 1'b1;
    end else if (consume) begin
      full_q <= 1'b0;
    end
  end

  // Phase counter walks 0..RATE-1 once per high-rate tick.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      phase_q <= '0;
    end else if (ce) begin
      if (phase_q == LAST_PHASE) phase_q <= '0;
      else                       phase_q <= phase_q + PW'(1);
    end
  end

  // Sticky underflow: a new underflow beats a coincident clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      underflow <= 1'b0;
    end else if (consume && !full_q) begin
      underflow <= 1'b1;
    end else if (clr_underflow) begin
      underflow <= 1'b0;
    end
  end

  // Comb chain: combinational differences, delays advance on consume only.
  for (genvar k = 0; k < STAGES; k++) begin : g_comb
    logic signed [ACC_WIDTH-1:0] din;
    logic signed [ACC_WIDTH-1:0] dout;
    logic signed [ACC_WIDTH-1:0] dly;

    if (k == 0) begin : g_head
      assign din = x_acc;
    end else begin : g_tail
      assign din = g_comb[k-1].dout;
    end

    assign dout = din - dly;

    // Remember the previous low-rate value of this stage's input.
    always_ff @(posedge clock) begin
      if (!reset_n)     dly <= '0;
      else if (consume) dly <= din;
    end
  end

  // Integrator chain: zero-stuffed comb output in, one registered hop per stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_integ
    logic signed [ACC_WIDTH-1:0] add;
    logic signed [ACC_WIDTH-1:0] acc;

    if (k == 0) begin : g_head
      assign add = consume ? g_comb[STAGES-1].dout : '0;
    end else begin : g_tail
      assign add = g_integ[k-1].acc;
    end

    // Accumulate modulo 2^ACC_WIDTH on every high-rate tick; wrap is intended.
    always_ff @(posedge clock) begin
      if (!reset_n) acc <= '0;
      else if (ce)  acc <= acc + add;
    end
  end

  // Output truncates the last integrator to its top OUT_WIDTH bits each tick.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_data   <= '0;
      out_strobe <= 1'b0;
    end else if (ce) begin
      out_data   <= g_integ[STAGES-1].acc[ACC_WIDTH-1 -: OUT_WIDTH];
      out_strobe <= 1'b1;
    end else begin
      out_strobe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator: random stimulus against an impulse-response reference model.
// Latency: outputs checked every clock, #1 after the rising edge.
// Backpressure: the model owns the holding-register rules and predicts in_ready.
module tb_cic_interpolator;

  localparam int IW   = 16;
  localparam int OW   = 16;
  localparam int R    = 4;
  localparam int N    = 3;
  localparam int AW   = IW + N * $clog2(R);
  localparam int HLEN = N * (R - 1) + 1;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 ce = 1'b0;
  logic signed [IW-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [OW-1:0] out_data;
  logic                 out_strobe;
  logic                 underflow;
  logic                 clr_underflow = 1'b0;

  always #5 clock = ~clock;

  cic_interpolator #(
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .RATE     (R),
    .STAGES   (N),
    .ACC_WIDTH(AW)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ce           (ce),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_strobe   (out_strobe),
    .underflow    (underflow),
    .clr_underflow(clr_underflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: end-to-end impulse response of the filter (boxcar^N),
  // applied to the zero-stuffed stream of consumed samples.
  longint h[HLEN];
  longint u_q[$];
  longint obs_q[$];
  bit     m_full;
  longint m_hold;
  int     m_phase;
  bit     m_uf;
  longint m_out;
  bit     m_strobe;
  bit     a;

  function automatic void build_h();
    longint t[HLEN];
    int len;
    for (int i = 0; i < HLEN; i++) h[i] = 0;
    h[0] = 1;
    len = 1;
    repeat (N) begin
      for (int i = 0; i < HLEN; i++) t[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < R; j++) t[i+j] += h[i];
      len += R - 1;
      for (int i = 0; i < HLEN; i++) h[i] = t[i];
    end
  endfunction

  function automatic void model_reset();
    m_full = 0; m_hold = 0; m_phase = 0; m_uf = 0; m_out = 0; m_strobe = 0;
    u_q.delete();
  endfunction

  function automatic longint model_out();
    longint acc;
    int m;
    int idx;
    logic [AW-1:0] wrapped;
    logic signed [OW-1:0] top;
    acc = 0;
    m = u_q.size() - 1;
    for (int j = 0; j < HLEN; j++) begin
      idx = m - N - j;
      if (idx >= 0) acc += h[j] * u_q[idx];
    end
    wrapped = acc[AW-1:0];
    top = wrapped[AW-1 -: OW];
    return longint'(top);
  endfunction

  function automatic longint obs_at(input int i);
    if (i < obs_q.size()) return obs_q[i];
    return 999999;
  endfunction

  // One clock: drive inputs, check ready, advance model, check outputs after the edge.
  task automatic step(input bit rst_n, input bit c, input bit v, input longint d,
                      input bit clr, output bit acc);
    bit ld;
    bit cons;
    reset_n = rst_n; ce = c; in_valid = v; in_data = d[IW-1:0]; clr_underflow = clr;
    acc = 0;
    #1;
    if (rst_n) check("in_ready", longint'(in_ready), longint'(!m_full));
    if (!rst_n) begin
      model_reset();
    end else begin
      ld   = v && !m_full;
      cons = c && (m_phase == 0);
      if (cons && !m_full) m_uf = 1;
      else if (clr)        m_uf = 0;
      if (c) begin
        u_q.push_back(cons ? (m_full ? m_hold : 0) : 0);
        m_out    = model_out();
        m_strobe = 1;
        m_phase  = (m_phase + 1) % R;
      end else begin
        m_strobe = 0;
      end
      if (ld) begin
        m_hold = longint'(in_data);
        m_full = 1;
      end else if (cons) begin
        m_full = 0;
      end
      acc = ld;
    end
    @(posedge clock);
    #1;
    check("out_strobe", longint'(out_strobe), longint'(m_strobe));
    check("out_data", longint'(out_data), m_out);
    check("underflow", longint'(underflow), longint'(m_uf));
    if (out_strobe) obs_q.push_back(longint'(out_data));
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 0, a);
  endtask

  int imp[10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

  initial begin
    int idx;
    int loads;
    bit tog;
    build_h();
    model_reset();
    @(posedge clock);
    #1;

    // Reset state.
    do_reset();
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_strobe", longint'(out_strobe), 0);
    check("rst_underflow", longint'(underflow), 0);

    // Impulse: 64 then valid zeros, ce every other clock.
    obs_q.delete();
    step(1, 0, 1, 64, 0, a);
    for (int k = 0; k < 40; k++) step(1, (k % 2) == 0, 1, 0, 0, a);
    check("imp_count", obs_q.size(), 20);
    for (int i = 0; i < 3; i++)  check("imp_pre", obs_at(i), 0);
    for (int i = 0; i < 10; i++) check("imp_resp", obs_at(3 + i), imp[i]);
    for (int i = 13; i < 20; i++) check("imp_tail", obs_at(i), 0);

    // DC: 1024 continuously valid, ce every clock.
    do_reset();
    obs_q.delete();
    step(1, 0, 1, 1024, 0, a);
    loads = 0;
    for (int k = 0; k < 80; k++) begin
      step(1, 1, 1, 1024, 0, a);
      if (k >= 40 && a) loads++;
    end
    check("dc_loads_per_40ce", loads, 10);
    for (int i = 16; i < 80; i += 4) check("dc_level", obs_at(i), 256);

    // Underflow set, hold, clear, and set-wins-over-clear.
    do_reset();
    obs_q.delete();
    step(1, 1, 0, 0, 0, a);
    check("uf_set", longint'(underflow), 1);
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0, a);
    check("uf_hold", longint'(underflow), 1);
    check("uf_zero_out", longint'(out_data), 0);
    step(1, 0, 0, 0, 1, a);
    check("uf_clear", longint'(underflow), 0);
    step(1, 1, 0, 0, 1, a);
    check("uf_set_wins", longint'(underflow), 1);
    for (int k = 0; k < 8; k++) step(1, 1, 0, 0, 0, a);
    check("uf_out_still_zero", longint'(out_data), 0);

    // Backpressure: always valid, indexed samples, random ce.
    do_reset();
    idx = 1;
    for (int k = 0; k < 600; k++) begin
      step(1, $urandom_range(0, 2) != 0, 1, longint'(idx) * 64, 0, a);
      if (a) idx++;
    end
    check("bp_progress", longint'(idx > 40), 1);

    // Wrap: alternating full-scale samples, random ce.
    do_reset();
    tog = 0;
    for (int k = 0; k < 600; k++) begin
      step(1, $urandom_range(0, 3) != 0, 1, tog ? -32768 : 32767, 0, a);
      if (a) tog = !tog;
    end

    // Reset mid impulse response.
    do_reset();
    step(1, 0, 1, 64, 0, a);
    for (int k = 0; k < 14; k++) step(1, (k % 2) == 0, 0, 0, 0, a);
    step(0, 1, 1, 500, 0, a);
    check("mid_rst_strobe", longint'(out_strobe), 0);
    check("mid_rst_ready", longint'(in_ready), 1);
    check("mid_rst_underflow", longint'(underflow), 0);
    for (int k = 0; k < 30; k++) begin
      step(1, (k % 2) == 0, 0, 0, 0, a);
      if (out_strobe) check("mid_rst_zero", longint'(out_data), 0);
    end
    for (int k = 0; k < 40; k++)
      step(1, $urandom_range(0, 1) == 1, 1, longint'($urandom_range(0, 65535)) - 32768, 0, a);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
